data_mem_responder: RTL and testbench

Data-memory responder on the far side of the execute stage's store/load interface. It accepts load and store requests (address, width, store data) and returns right-aligned, zero-filled load data. Sign extension stays in the execute stage. It is backed by an internal word-organised synchronous RAM and handles misaligned accesses that cross a word boundary by splitting them into two RAM cycles under a small FSM.

---
 rtl/data_mem_responder.sv | 132 +++++++++++++
 tb/tb_data_mem_responder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised synchronous RAM behind a load/store
// request port. Accesses that straddle a word boundary are split into two RAM cycles.
module data_mem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_width,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, SECOND, RESP} state_t;
  state_t state, state_nx;

  logic [31:0] mem [DEPTH_WORDS];

  logic          is_store_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    width_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rd0, rd1;

  logic          accept, do_second;
  logic          cur_store;
  logic [AW+1:0] cur_addr;
  logic [1:0]    cur_width, lane;
  logic [31:0]   cur_wdata, wmask;
  logic [AW-1:0] idx, idx1;
  logic [3:0]    be_base;
  logic [7:0]    be_ext;
  logic [63:0]   wd_ext;
  logic          crosses;
  logic [31:0]   rmask, rasm;
  logic          unused_addr;

  assign unused_addr = ^{req_addr[XLEN-1:AW+2], req_wdata[XLEN-1:32]};

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign do_second = (state == SECOND) && !reset;

  // The first word access uses the live request; later cycles use the held copy.
  assign cur_store = (state == IDLE) ? req_is_store     : is_store_q;
  assign cur_addr  = (state == IDLE) ? req_addr[AW+1:0] : addr_q;
  assign cur_width = (state == IDLE) ? req_width        : width_q;
  assign cur_wdata = (state == IDLE) ? req_wdata[31:0]  : wdata_q;

  assign lane = cur_addr[1:0];
  assign idx  = cur_addr[AW+1:2];
  assign idx1 = idx + 1'b1;

  always_comb begin
    be_base = 4'b1111;
    wmask   = 32'hffff_ffff;
    case (cur_width)
      2'd0: begin be_base = 4'b0001; wmask = 32'h0000_00ff; end
      2'd1: begin be_base = 4'b0011; wmask = 32'h0000_ffff; end
      default: ;
    endcase
  end

  // Lanes 0-3 of the shifted enables/data land in word N, lanes 4-7 in word N+1.
  assign be_ext  = {4'b0000, be_base} << lane;
  assign wd_ext  = {32'b0, cur_wdata & wmask} << {lane, 3'b000};
  assign crosses = |be_ext[7:4];

  always_ff @(posedge clk) begin
    if (accept && cur_store) begin
      for (int k = 0; k < 4; k++)
        if (be_ext[k]) mem[idx][8*k +: 8] <= wd_ext[8*k +: 8];
    end
    if (do_second && cur_store) begin
      for (int k = 0; k < 4; k++)
        if (be_ext[4+k]) mem[idx1][8*k +: 8] <= wd_ext[32+8*k +: 8];
    end
    if (accept && !cur_store)    rd0 <= mem[idx];
    if (do_second && !cur_store) rd1 <= mem[idx1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      width_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        is_store_q <= req_is_store;
        addr_q     <= req_addr[AW+1:0];
        width_q    <= req_width;
        wdata_q    <= req_wdata[31:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = crosses ? SECOND : RESP;
      SECOND:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rmask = 32'hffff_ffff;
    case (width_q)
      2'd0:    rmask = 32'h0000_00ff;
      2'd1:    rmask = 32'h0000_ffff;
      default: ;
    endcase
  end

  // Word N supplies lanes [lane..3], word N+1 the rest; mask clears bytes above width.
  logic [63:0] rcat;
  assign rcat = {rd1, rd0} >> {addr_q[1:0], 3'b000};
  assign rasm = rcat[31:0] & rmask;

  assign resp_valid = (state == RESP) && !reset;
  assign resp_rdata = (resp_valid && !is_store_q) ? XLEN'(rasm) : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed steps plus random
// traffic checked against a byte-array memory model.
module tb_data_mem_responder;
  localparam int XLEN  = 32;
  localparam int DEPTH = 1024;
  localparam int BYTES = 4 * DEPTH;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid, req_ready, req_is_store;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic [1:0]      req_width;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] mref [BYTES];

  always #5 clk = ~clk;

  data_mem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_addr(req_addr), .req_width(req_width),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  task automatic op(input logic st, input logic [31:0] a, input logic [1:0] w,
                    input logic [31:0] d, output logic [31:0] r);
    int nb, lat, g;
    logic [31:0] exp_r;
    int exp_lat;
    nb = nbytes(w);
    // A second RAM cycle is needed whenever the last byte lands in the next word.
    exp_lat = ((a % 4) + nb > 4) ? 2 : 1;
    exp_r = 0;
    for (int k = 0; k < nb; k++) begin
      int unsigned bi;
      bi = (a + k) % BYTES;
      if (st) mref[bi] = d[8*k +: 8];
      else    exp_r = exp_r | (32'(mref[bi]) << (8*k));
    end
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_addr = a; req_width = w; req_wdata = d;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 8);
    check("latency", 32'(lat), 32'(exp_lat));
    r = resp_rdata;
    check(st ? "store_rdata_zero" : "load_rdata", r, exp_r);
    @(negedge clk);
    check("resp_pulse_one_cycle", 32'(resp_valid), 32'd0);
    check("rdata_idle_zero", resp_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; req_valid = 1'b1; req_is_store = 1'b0;
    req_addr = '0; req_width = 2'd2; req_wdata = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_ready", 32'(req_ready), 32'd0);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_rdata", resp_rdata, 32'd0);
    end
    req_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Give the RAM and the model a known all-zero starting image.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 32'(i * 4), 2'd2, 32'd0, r);

    op(1'b1, 32'h100, 2'd2, 32'h11223344, r);
    op(1'b0, 32'h100, 2'd2, 32'h0, r);        check("ld_w_100", r, 32'h11223344);
    op(1'b1, 32'h101, 2'd0, 32'hFFFF_FFAB, r);
    op(1'b0, 32'h100, 2'd2, 32'h0, r);        check("ld_w_after_sb", r, 32'h1122AB44);
    op(1'b0, 32'h101, 2'd0, 32'h0, r);        check("ld_b_101", r, 32'h000000AB);
    op(1'b0, 32'h102, 2'd1, 32'h0, r);        check("ld_h_102", r, 32'h00001122);

    op(1'b1, 32'h103, 2'd2, 32'hAABBCCDD, r);
    op(1'b0, 32'h100, 2'd2, 32'h0, r);        check("ld_w_100_b3", r, 32'hDD22AB44);
    op(1'b0, 32'h104, 2'd2, 32'h0, r);        check("ld_w_104_low3", r & 32'h00FF_FFFF, 32'h00AABBCC);
    op(1'b0, 32'h103, 2'd2, 32'h0, r);        check("ld_w_103_cross", r, 32'hAABBCCDD);
    op(1'b0, 32'h101, 2'd3, 32'h0, r);        check("ld_width3_as_word", r, 32'hCCDD22AB);

    op(1'b1, 32'hFFF, 2'd1, 32'h1234BEEF, r);
    op(1'b0, 32'hFFF, 2'd0, 32'h0, r);        check("wrap_b_fff", r, 32'h000000EF);
    op(1'b0, 32'h000, 2'd0, 32'h0, r);        check("wrap_b_000", r, 32'h000000BE);
    op(1'b0, 32'hFFF, 2'd1, 32'h0, r);        check("wrap_h_fff", r, 32'h0000BEEF);

    // Reset while the second half of a crossing store is pending.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_addr = 32'h202;
    req_width = 2'd2; req_wdata = 32'h12345678;
    check("midrst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0; reset = 1'b1;
    mref[32'h202] = 8'h78; mref[32'h203] = 8'h56;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_resp", 32'(resp_valid), 32'd0);
    end
    reset = 1'b0;
    op(1'b0, 32'h200, 2'd2, 32'h0, r);        check("midrst_w200", r, 32'h56780000);
    op(1'b0, 32'h204, 2'd2, 32'h0, r);        check("midrst_w204", r, 32'h00000000);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom % 2 == 0) ? 32'($urandom_range(0, 31)) : 32'($urandom_range(4064, 4095));
      op(1'($urandom % 2), a, 2'($urandom_range(0, 3)), $urandom, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
